// File: rtl/muxl2_if.sv
// Lane bundle between the 4:2 clk_2f mux and the 2:1 clk_4f serializer,
// carrying the two input lanes and the serialized output with its status.
interface muxl2_if #(
  parameter int unsigned CNT_W = 16
);
  logic [7:0]       data_00;
  logic             valid_00;
  logic [7:0]       data_11;
  logic             valid_11;
  logic [7:0]       data_000;
  logic             valid_000;
  logic             active;
  logic [CNT_W-1:0] byte_count;
  logic             phase;

  modport master (
    output data_00, valid_00, data_11, valid_11,
    input  data_000, valid_000, active, byte_count, phase
  );

  modport slave (
    input  data_00, valid_00, data_11, valid_11,
    output data_000, valid_000, active, byte_count, phase
  );
endinterface

// File: rtl/muxl2_serializer.sv
// 2:1 serializer: interleaves two clk_2f byte lanes onto one clk_4f lane,
// substitutes an idle symbol for invalid bytes and tracks link activity.
module muxl2_serializer #(
  parameter logic [7:0]  IDLE_CODE  = 8'hBC,
  parameter int unsigned IDLE_LIMIT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic    clk_4f,
  input  logic    reset,
  muxl2_if.slave  bus
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [3:0] RUN_LAST = 4'(IDLE_LIMIT - 1);

  logic             phase_q;

  logic [7:0]       hold_d0_p0;
  logic [7:0]       hold_d1_p0;
  logic             vld0_p0;
  logic             vld1_p0;

  logic [7:0]       src_d;
  logic             src_v;

  logic [7:0]       data_p1;
  logic             vld_p1;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       run_q;
  logic [3:0]       run_d;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [7:0] map_byte(input logic [7:0] d, input logic v);
    return v ? d : IDLE_CODE;
  endfunction

  always_ff @(posedge clk_4f) begin
    if (reset) phase_q <= 1'b0;
    else       phase_q <= ~phase_q;
  end

  // Stage p0: pair hold register, written on phase-0 edges only
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      vld0_p0 <= 1'b0;
      vld1_p0 <= 1'b0;
    end else if (!phase_q) begin
      vld0_p0 <= bus.valid_00;
      vld1_p0 <= bus.valid_11;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!phase_q) begin
      hold_d0_p0 <= bus.data_00;
      hold_d1_p0 <= bus.data_11;
    end
  end

  // Phase 0 drains the previous pair's lane 1 while the new pair is captured.
  always_comb begin
    src_d = hold_d1_p0;
    src_v = vld1_p0;
    if (phase_q) begin
      src_d = hold_d0_p0;
      src_v = vld0_p0;
    end
  end

  // Stage p1: serialized output register
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      data_p1 <= IDLE_CODE;
      vld_p1  <= 1'b0;
    end else begin
      data_p1 <= map_byte(src_d, src_v);
      vld_p1  <= src_v;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= S_IDLE;
      run_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      S_IDLE: begin
        if (src_v) begin
          state_d = S_ACTIVE;
          run_d   = 4'd0;
        end
      end
      S_ACTIVE: begin
        if (src_v) begin
          run_d = 4'd0;
        end else if (run_q == RUN_LAST) begin
          state_d = S_IDLE;
          run_d   = 4'd0;
        end else begin
          run_d = run_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        run_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset)      cnt_q <= '0;
    else if (src_v) cnt_q <= sat_inc(cnt_q);
  end

  assign bus.data_000   = data_p1;
  assign bus.valid_000  = vld_p1;
  assign bus.active     = (state_q == S_ACTIVE);
  assign bus.byte_count = cnt_q;
  assign bus.phase      = phase_q;

endmodule

// File: tb/tb_muxl2_serializer.sv
// Bench for muxl2_serializer: directed steps plus random pairs, checked every
// clk_4f edge against a byte-queue model of the serialized stream.
module tb_muxl2_serializer;

  localparam logic [7:0] IDLE_CODE  = 8'hBC;
  localparam int         IDLE_LIMIT = 4;
  localparam int         CNT_W      = 4;
  localparam int         CNT_MAX    = (1 << CNT_W) - 1;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_4f = ~clk_4f;

  muxl2_if #(.CNT_W(CNT_W)) bus ();

  muxl2_serializer #(
    .IDLE_CODE (IDLE_CODE),
    .IDLE_LIMIT(IDLE_LIMIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_4f(clk_4f),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Model: bytes waiting to be emitted, {valid, data}, in stream order.
  logic [8:0] q[$];
  logic       m_ph;
  logic [7:0] e_d;
  logic       e_v;
  logic       m_act;
  int         m_run;
  int         m_cnt;
  int         checks = 0;
  int         passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    logic [8:0] b;
    @(posedge clk_4f);
    if (reset) begin
      q.delete();
      q.push_back(9'h000);
      m_ph  = 1'b0;
      e_d   = IDLE_CODE;
      e_v   = 1'b0;
      m_act = 1'b0;
      m_run = 0;
      m_cnt = 0;
    end else begin
      b = (q.size() > 0) ? q.pop_front() : 9'h000;
      e_v = b[8];
      e_d = b[8] ? b[7:0] : IDLE_CODE;
      if (b[8]) begin
        m_act = 1'b1;
        m_run = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else if (m_act) begin
        m_run++;
        if (m_run == IDLE_LIMIT) begin
          m_act = 1'b0;
          m_run = 0;
        end
      end
      if (!m_ph) begin
        q.push_back({bus.valid_00, bus.data_00});
        q.push_back({bus.valid_11, bus.data_11});
      end
      m_ph = ~m_ph;
    end
    #1;
    chk("data_000",   32'(bus.data_000),   32'(e_d));
    chk("valid_000",  32'(bus.valid_000),  32'(e_v));
    chk("active",     32'(bus.active),     32'(m_act));
    chk("byte_count", 32'(bus.byte_count), 32'(m_cnt));
    chk("phase",      32'(bus.phase),      32'(m_ph));
  endtask

  task automatic drive(input logic [7:0] d0, input logic v0,
                       input logic [7:0] d1, input logic v1);
    bus.data_00  = d0;
    bus.valid_00 = v0;
    bus.data_11  = d1;
    bus.valid_11 = v1;
  endtask

  task automatic send_pair(input logic [7:0] d0, input logic v0,
                           input logic [7:0] d1, input logic v1);
    drive(d0, v0, d1, v1);
    tick();
    tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    drive(8'h00, 1'b0, 8'h00, 1'b0);

    // Reset, then idle pairs with junk data on invalid lanes.
    do_reset(2);
    for (int i = 0; i < 4; i++)
      send_pair(8'($urandom), 1'b0, 8'($urandom), 1'b0);

    // All-valid pairs, then lane-0 invalid with lane-1 valid.
    send_pair(8'hFF, 1'b1, 8'hEE, 1'b1);
    send_pair(8'hDD, 1'b1, 8'hCC, 1'b1);
    send_pair(8'h12, 1'b0, 8'h77, 1'b1);
    chk("cnt_after_77_pair_lane0", 32'(bus.byte_count), 32'd4);

    // Three invalids then a valid byte keeps the link active.
    send_pair(8'h01, 1'b0, 8'h02, 1'b0);
    send_pair(8'h03, 1'b0, 8'h55, 1'b1);
    tick();
    chk("active_after_3_idles", 32'(bus.active), 32'd1);
    tick();

    // Four consecutive invalids drop the link.
    for (int i = 0; i < 3; i++)
      send_pair(8'h00, 1'b0, 8'h00, 1'b0);
    chk("active_after_idle_run", 32'(bus.active), 32'd0);

    // Reset on the phase-1 cycle right after capturing (AA,99).
    send_pair(8'h31, 1'b1, 8'h32, 1'b1);
    drive(8'hAA, 1'b1, 8'h99, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_aa_99", 32'(bus.data_000 == 8'hAA || bus.data_000 == 8'h99), 32'd0);
    end

    // Saturate byte_count with more than 20 valid bytes.
    for (int i = 0; i < 11; i++)
      send_pair(8'(2 * i), 1'b1, 8'(2 * i + 1), 1'b1);
    chk("byte_count_sat", 32'(bus.byte_count), 32'hF);

    // Random pairs with varying valid density and occasional resets.
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      int pct;
      pct = (i / 30) % 2 == 0 ? 80 : 15;
      if ($urandom_range(0, 49) == 0) begin
        drive(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      send_pair(8'($urandom), 1'($urandom_range(0, 99) < pct),
                8'($urandom), 1'($urandom_range(0, 99) < pct));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
